spi_osd_ram: RTL and testbench
==============================

SPI_OSD_RAM -- requirements
Module: spi_osd_ram

Interface
REQ-001 The block SHALL have parameter c_addr_bits, default 32, SPI address width.
REQ-002 The block SHALL have parameter c_addr_osd, default 8'hF0, high address byte of the bitmap window.
REQ-003 The block SHALL have parameter c_addr_ctrl, default 8'hFD, high address byte of the control register.
REQ-004 The block SHALL have parameters c_start_x, default 64, and c_start_y, default 48, giving the OSD top-left pixel position.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have inputs spi_rd, spi_wr (1 bit each), spi_addr (c_addr_bits) and spi_data_in (8 bits): the SPI slave bus request and write data.
REQ-008 The block SHALL have output spi_data_out, 8 bits: read data returned to the SPI slave.
REQ-009 The block SHALL have inputs ce, de, hsync, vsync, 1 bit each: pixel enable and video timing.
REQ-010 The block SHALL have outputs osd_de, osd_hsync, osd_vsync, 1 bit each: timing delayed to align with the pixel.
REQ-011 The block SHALL have outputs osd_active and osd_pixel, 1 bit each: pixel inside the enabled OSD window, and the bitmap bit.

Function
REQ-012 Bitmap SHALL be 256x64 mono, 2048 bytes, row-major, 32 bytes/row, MSB = leftmost pixel.
REQ-013 Bitmap SHALL be true dual-port: port A for SPI read/write, port B for video read.
REQ-014 SPI write, on spi_wr=1 with spi_addr[top 8]=c_addr_osd: byte spi_data_in SHALL be written at spi_addr[10:0]; higher offset bits are ignored, so offsets wrap modulo 2048.
REQ-015 SPI write with top byte = c_addr_ctrl SHALL load ctrl_pending <= spi_data_in[0]; writes to any other address SHALL be ignored.
REQ-016 SPI read SHALL present registered data on spi_data_out 1 clk after spi_rd=1: bitmap byte, {7'b0,ctrl_pending}, or 8'h00 for unmapped addresses.
REQ-017 ctrl_active SHALL take ctrl_pending on the rising edge of vsync only, so enable/disable changes take effect per frame.
REQ-018 x counter SHALL increment on ce&de and clear when de is low; y counter SHALL increment on the de falling edge (with ce) and clear on the vsync rising edge.
REQ-019 A pixel SHALL be in the window when c_start_x<=x<c_start_x+256 and c_start_y<=y<c_start_y+64.
REQ-020 Video fetch address SHALL be (y-c_start_y)*32+(x-c_start_x)[7:3], and the bit SHALL be selected by 7-(x-c_start_x)[2:0].
REQ-021 The pipeline SHALL advance only on ce; osd_* outputs SHALL lag de/hsync/vsync by exactly 2 ce cycles (address register, RAM read).
REQ-022 osd_active SHALL be window & ctrl_active; osd_pixel SHALL be the bitmap bit AND osd_active.
REQ-023 On a same-cycle SPI write and video read of the same byte, the video port SHALL return old data (read-first).
REQ-024 Simultaneous spi_rd and spi_wr SHALL perform the write; spi_data_out SHALL then return the pre-write byte.

Reset
REQ-025 On resetn=0, all outputs SHALL be 0 and ctrl_pending, ctrl_active, x, y and the pipeline registers SHALL be 0; bitmap contents SHALL NOT be cleared.
REQ-026 Reset mid-frame SHALL force OSD off until ctrl is rewritten and the next vsync rising edge occurs.

Structure
REQ-027 A shared package SHALL hold the bitmap geometry constants (width 256, height 64, bytes/row 32, depth 2048) and the default window/control address bytes.
REQ-028 The bitmap SHALL be one sub-module, osd_bram_dp (read-first true dual-port, 2048x8); all other logic stays in spi_osd_ram.

Verification
REQ-029 Bench SHALL write 8'hA5 at 0xF0000000 and then read the same address -> spi_data_out=8'hA5 1 clk after spi_rd.
REQ-030 Bench SHALL write 8'h3C at 0xF0000805 and then read 0xF0000005 -> 8'h3C (wrap); a read of 0xE0000000 -> 8'h00.
REQ-031 Bench SHALL write ctrl=1 mid-frame -> osd_active stays 0 until after the next vsync rise, then goes 1 at pixel (64,48) with 2-ce latency.
REQ-032 Bench SHALL load byte 0 = 8'h80 with OSD enabled -> osd_pixel=1 only at x=64,y=48 and 0 at x=65..71.
REQ-033 Bench SHALL assert resetn=0 mid-line -> all outputs 0 immediately; after release with no ctrl write and a vsync, osd_active stays 0 while the bitmap read-back is unchanged.
REQ-034 Bench SHALL drive ce at 1-in-2 -> the osd_* to de/hsync/vsync lag stays exactly 2 ce pulses.

Source files
------------

// File: rtl/spi_osd_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_osd_ram_pkg
// Desc   : Bitmap geometry, default SPI address bytes and shared types.
// Rev    : 1.0 - initial release
// ============================================================================
package spi_osd_ram_pkg;

  localparam int c_osd_width     = 256;
  localparam int c_osd_height    = 64;
  localparam int c_osd_row_bytes = 32;
  localparam int c_osd_depth     = 2048;
  localparam int c_osd_aw        = $clog2(c_osd_depth);
  localparam int c_row_bits      = $clog2(c_osd_height);
  localparam int c_col_bits      = $clog2(c_osd_row_bytes);

  localparam logic [7:0] c_def_addr_osd  = 8'hF0;
  localparam logic [7:0] c_def_addr_ctrl = 8'hFD;

  localparam int c_cnt_bits = 12;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BITMAP = 2'd1,
    RD_CTRL   = 2'd2
  } rd_sel_t;

endpackage
`default_nettype wire

// File: rtl/osd_bram_dp.sv
`default_nettype none
// ============================================================================
// Module : osd_bram_dp
// Desc   : Read-first dual-port 2048x8 bitmap; port A read/write, port B read.
// Rev    : 1.0 - initial release
// ============================================================================
module osd_bram_dp
  import spi_osd_ram_pkg::*;
(
  input  logic                clk,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [c_osd_aw-1:0] addr_a,
  input  logic [7:0]          din_a,
  output logic [7:0]          dout_a,
  input  logic                en_b,
  input  logic [c_osd_aw-1:0] addr_b,
  output logic [7:0]          dout_b
);

  logic [7:0] r_mem [c_osd_depth];

  // Non-blocking reads sample the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we_a) r_mem[addr_a] <= din_a;
    if (en_a) dout_a <= r_mem[addr_a];
    if (en_b) dout_b <= r_mem[addr_b];
  end

endmodule
`default_nettype wire

// File: rtl/spi_osd_ram.sv
`default_nettype none
// ============================================================================
// Module : spi_osd_ram
// Desc   : SPI-loaded 256x64 mono OSD bitmap overlaid on a video timing stream.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_osd_ram
  import spi_osd_ram_pkg::*;
#(
  parameter int         c_addr_bits = 32,
  parameter logic [7:0] c_addr_osd  = c_def_addr_osd,
  parameter logic [7:0] c_addr_ctrl = c_def_addr_ctrl,
  parameter int         c_start_x   = 64,
  parameter int         c_start_y   = 48
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   spi_rd,
  input  logic                   spi_wr,
  input  logic [c_addr_bits-1:0] spi_addr,
  input  logic [7:0]             spi_data_in,
  output logic [7:0]             spi_data_out,
  input  logic                   ce,
  input  logic                   de,
  input  logic                   hsync,
  input  logic                   vsync,
  output logic                   osd_de,
  output logic                   osd_hsync,
  output logic                   osd_vsync,
  output logic                   osd_active,
  output logic                   osd_pixel
);

  localparam logic [c_cnt_bits-1:0] c_x0      = c_cnt_bits'(c_start_x);
  localparam logic [c_cnt_bits-1:0] c_y0      = c_cnt_bits'(c_start_y);
  localparam logic [c_cnt_bits-1:0] c_win_w   = c_cnt_bits'(c_osd_width);
  localparam logic [c_cnt_bits-1:0] c_win_h   = c_cnt_bits'(c_osd_height);
  localparam logic [c_cnt_bits-1:0] c_cnt_one = c_cnt_bits'(1);

  // ---------------- SPI side ----------------
  logic [7:0] w_addr_hi;
  logic       w_hit_osd;
  logic       w_hit_ctrl;
  logic       w_unused_addr_bits;
  logic [7:0] w_ram_q_a;
  logic [7:0] w_ram_q_b;
  logic       r_ctrl_pending;
  logic       r_ctrl_rdval;
  rd_sel_t    r_rd_sel;

  assign w_addr_hi          = spi_addr[c_addr_bits-1 -: 8];
  assign w_hit_osd          = (w_addr_hi == c_addr_osd);
  assign w_hit_ctrl         = (w_addr_hi == c_addr_ctrl);
  assign w_unused_addr_bits = ^spi_addr[c_addr_bits-9:c_osd_aw];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl_pending <= 1'b0;
      r_ctrl_rdval   <= 1'b0;
      r_rd_sel       <= RD_NONE;
    end else begin
      if (spi_wr && w_hit_ctrl) r_ctrl_pending <= spi_data_in[0];
      // Captures the pre-write value when read and write coincide.
      if (spi_rd) begin
        r_ctrl_rdval <= r_ctrl_pending;
        if (w_hit_osd)       r_rd_sel <= RD_BITMAP;
        else if (w_hit_ctrl) r_rd_sel <= RD_CTRL;
        else                 r_rd_sel <= RD_NONE;
      end
    end
  end

  always_comb begin
    spi_data_out = 8'h00;
    case (r_rd_sel)
      RD_BITMAP: spi_data_out = w_ram_q_a;
      RD_CTRL:   spi_data_out = {7'b0, r_ctrl_rdval};
      default:   spi_data_out = 8'h00;
    endcase
  end

  // ---------------- Video side ----------------
  logic [c_cnt_bits-1:0] r_x;
  logic [c_cnt_bits-1:0] r_y;
  logic                  r_de_d;
  logic                  r_vs_d;
  logic                  r_ctrl_active;
  logic [c_cnt_bits-1:0] w_rel_x;
  logic [c_cnt_bits-1:0] w_rel_y;
  logic                  w_in_win;
  logic [c_osd_aw-1:0]   r_addr_s1;
  logic [2:0]            r_bit_s1;
  logic [2:0]            r_bit_s2;
  logic                  r_act_s1;
  logic                  r_act_s2;
  logic [2:0]            r_tim_s1;
  logic [2:0]            r_tim_s2;

  // Offsets below the start wrap to large values, so one compare bounds both sides.
  assign w_rel_x  = r_x - c_x0;
  assign w_rel_y  = r_y - c_y0;
  assign w_in_win = de && (w_rel_x < c_win_w) && (w_rel_y < c_win_h);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x           <= '0;
      r_y           <= '0;
      r_de_d        <= 1'b0;
      r_vs_d        <= 1'b0;
      r_ctrl_active <= 1'b0;
      r_addr_s1     <= '0;
      r_bit_s1      <= '0;
      r_bit_s2      <= '0;
      r_act_s1      <= 1'b0;
      r_act_s2      <= 1'b0;
      r_tim_s1      <= '0;
      r_tim_s2      <= '0;
    end else if (ce) begin
      r_de_d <= de;
      r_vs_d <= vsync;
      r_x    <= de ? r_x + c_cnt_one : '0;
      if (vsync && !r_vs_d) begin
        r_y           <= '0;
        r_ctrl_active <= r_ctrl_pending;
      end else if (r_de_d && !de) begin
        r_y <= r_y + c_cnt_one;
      end
      r_addr_s1 <= {w_rel_y[c_row_bits-1:0], w_rel_x[c_col_bits+2:3]};
      r_bit_s1  <= w_rel_x[2:0];
      r_act_s1  <= w_in_win && r_ctrl_active;
      r_tim_s1  <= {de, hsync, vsync};
      r_bit_s2  <= r_bit_s1;
      r_act_s2  <= r_act_s1;
      r_tim_s2  <= r_tim_s1;
    end
  end

  osd_bram_dp u_bram (
    .clk    (clk),
    .en_a   (spi_rd),
    .we_a   (spi_wr && w_hit_osd),
    .addr_a (spi_addr[c_osd_aw-1:0]),
    .din_a  (spi_data_in),
    .dout_a (w_ram_q_a),
    .en_b   (ce),
    .addr_b (r_addr_s1),
    .dout_b (w_ram_q_b)
  );

  assign osd_de     = r_tim_s2[2];
  assign osd_hsync  = r_tim_s2[1];
  assign osd_vsync  = r_tim_s2[0];
  assign osd_active = r_act_s2;
  // MSB is the leftmost pixel, so bit index is 7 - offset, i.e. the inverted offset.
  assign osd_pixel  = r_act_s2 && w_ram_q_b[~r_bit_s2];

endmodule
`default_nettype wire

// File: tb/tb_spi_osd_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_spi_osd_ram
// Desc   : Randomized self-checking bench for spi_osd_ram against a frame model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_spi_osd_ram;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_rd = 1'b0;
  logic        spi_wr = 1'b0;
  logic [31:0] spi_addr = '0;
  logic [7:0]  spi_data_in = '0;
  logic [7:0]  spi_data_out;
  logic        ce = 1'b0, de = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic        osd_de, osd_hsync, osd_vsync, osd_active, osd_pixel;

  always #5 clk = ~clk;

  spi_osd_ram dut (
    .clk          (clk),
    .resetn       (resetn),
    .spi_rd       (spi_rd),
    .spi_wr       (spi_wr),
    .spi_addr     (spi_addr),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .ce           (ce),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .osd_de       (osd_de),
    .osd_hsync    (osd_hsync),
    .osd_vsync    (osd_vsync),
    .osd_active   (osd_active),
    .osd_pixel    (osd_pixel)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_mem [0:2047];
  logic       m_pending = 1'b0;
  logic       m_active  = 1'b0;
  logic [4:0] q[$];
  logic [4:0] last_exp = '0;
  int         ce_mode = 0;
  bit         ce_ph = 1'b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [31:0] a);
    if (a[31:24] == 8'hF0) return m_mem[a[10:0]];
    if (a[31:24] == 8'hFD) return {7'b0, m_pending};
    return 8'h00;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [7:0] d);
    if (a[31:24] == 8'hF0)      m_mem[a[10:0]] = d;
    else if (a[31:24] == 8'hFD) m_pending = d[0];
  endfunction

  function automatic logic in_win(input int px, input int ln);
    return (px >= 64) && (px < 64 + 256) && (ln >= 48) && (ln < 48 + 64);
  endfunction

  function automatic logic m_bit(input int px, input int ln);
    logic [7:0] b;
    b = m_mem[(ln - 48) * 32 + (px - 64) / 8];
    return b[7 - ((px - 64) % 8)];
  endfunction

  task automatic reset_model();
    m_pending = 1'b0;
    m_active  = 1'b0;
    q.delete();
    q.push_back(5'd0);
    last_exp = 5'd0;
  endtask

  task automatic spi_write(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b0; spi_wr = 1'b1; spi_rd = 1'b0; spi_addr = a; spi_data_in = d;
    m_write(a, d);
    @(posedge clk); #1;
    spi_wr = 1'b0;
  endtask

  task automatic spi_read(input logic [31:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    ce = 1'b0; spi_rd = 1'b1; spi_wr = 1'b0; spi_addr = a;
    @(posedge clk); #1;
    check(tag, spi_data_out, exp);
    spi_rd = 1'b0;
  endtask

  task automatic spi_rw(input logic [31:0] a, input logic [7:0] d);
    logic [7:0] old;
    old = m_read(a);
    @(negedge clk);
    ce = 1'b0; spi_rd = 1'b1; spi_wr = 1'b1; spi_addr = a; spi_data_in = d;
    m_write(a, d);
    @(posedge clk); #1;
    check("spi_rw_old", spi_data_out, old);
    spi_rd = 1'b0; spi_wr = 1'b0;
  endtask

  // One ce pulse worth of video; outputs after ce edge n must equal the pixel from ce edge n-1.
  task automatic vstep(input logic d, input logic h, input logic v, input logic a,
                       input logic p);
    bit c;
    do begin
      @(negedge clk);
      case (ce_mode)
        0:       c = 1'b1;
        1:       begin c = ce_ph; ce_ph = ~ce_ph; end
        default: c = ($urandom % 3) != 0;
      endcase
      ce = c; de = d; hsync = h; vsync = v;
      @(posedge clk); #1;
      if (c) begin
        q.push_back({d, h, v, a, p});
        last_exp = q.pop_front();
      end
      check("video", {osd_de, osd_hsync, osd_vsync, osd_active, osd_pixel}, last_exp);
    end while (!c);
  endtask

  task automatic reset_mid();
    #2 resetn = 1'b0;
    #1 check("rst_async_outs",
             {spi_data_out, osd_de, osd_hsync, osd_vsync, osd_active, osd_pixel}, 0);
    ce = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    reset_model();
  endtask

  task automatic run_frame(input int mode, input int ctrl_line, input logic [7:0] ctrl_val,
                           input int rst_line, input int rst_px);
    int   len;
    logic a;
    ce_mode  = mode;
    m_active = m_pending;
    vstep(0, 0, 1, 0, 0);
    vstep(0, 0, 1, 0, 0);
    vstep(0, 0, 0, 0, 0);
    for (int ln = 0; ln < 113; ln++) begin
      len = (ln inside {47, 48, 49, 50, 110, 111, 112}) ? 321 + int'($urandom % 6) : 4;
      for (int px = 0; px < len; px++) begin
        a = m_active && in_win(px, ln);
        vstep(1, 0, 0, a, a && m_bit(px, ln));
        if (ln == rst_line && px == rst_px) begin
          reset_mid();
          return;
        end
      end
      vstep(0, 1, 0, 0, 0);
      vstep(0, 1, 0, 0, 0);
      vstep(0, 0, 0, 0, 0);
      if (ln == ctrl_line) spi_write(32'hFD00_0000, ctrl_val);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  top;
    reset_model();
    repeat (3) @(posedge clk);
    #1 check("reset_outs",
             {spi_data_out, osd_de, osd_hsync, osd_vsync, osd_active, osd_pixel}, 0);
    @(negedge clk) resetn = 1'b1;

    // Fill the bitmap with random bytes through random upper offset bits.
    for (int i = 0; i < 2048; i++)
      spi_write({8'hF0, 13'($urandom), 11'(i)}, 8'($urandom));

    spi_write(32'hF000_0000, 8'hA5);
    spi_read (32'hF000_0000, 8'hA5, "rd_a5");
    spi_write(32'hF000_0805, 8'h3C);
    spi_read (32'hF000_0005, 8'h3C, "rd_wrap");
    spi_read (32'hE000_0000, 8'h00, "rd_unmapped");
    spi_read (32'hFD00_0000, 8'h00, "rd_ctrl_reset");

    for (int i = 0; i < 60; i++) begin
      case ($urandom % 4)
        0: begin
          do top = 8'($urandom); while (top == 8'hF0 || top == 8'hFD);
          spi_write({top, 24'($urandom)}, 8'($urandom));
        end
        1: spi_write({8'hF0, 24'($urandom)}, 8'($urandom));
        2: spi_rw({($urandom % 2) ? 8'hF0 : 8'hFD, 24'($urandom)}, 8'($urandom));
        default: begin
          case ($urandom % 3)
            0:       top = 8'hF0;
            1:       top = 8'hFD;
            default: top = 8'($urandom);
          endcase
          a = {top, 24'($urandom)};
          spi_read(a, m_read(a), "rd_rand");
        end
      endcase
    end
    spi_write(32'hFD00_0000, 8'h00);

    run_frame(0, 30, 8'h01, -1, -1);
    spi_write(32'hF000_0000, 8'h80);
    run_frame(0, -1, 8'h00, -1, -1);
    run_frame(1, -1, 8'h00, -1, -1);
    run_frame(2, 60, 8'h00, -1, -1);
    run_frame(0, 100, 8'h01, -1, -1);
    spi_read(32'hFD00_0000, 8'h01, "rd_ctrl_on");
    run_frame(0, -1, 8'h00, 49, 100);

    for (int i = 0; i < 16; i++) begin
      a = {8'hF0, 24'($urandom)};
      spi_read(a, m_read(a), "rd_after_rst");
    end
    spi_read(32'hFD00_0000, 8'h00, "rd_ctrl_after_rst");
    run_frame(1, -1, 8'h00, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
